// File: rtl/conv1_window_buf.sv
// Streaming 5x5 window generator for the layer-1 convolution stage.
// A raster-order pixel stream fills a shift-register line buffer; each fully valid kernel position emits one window.
module conv1_window_buf #(
  parameter int IMG_WIDTH = 28,
  parameter int KERNEL    = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_in,
  input  logic [DATA_BITS-1:0]                data_in,
  output logic [KERNEL*KERNEL*DATA_BITS-1:0]  window_out,
  output logic                                valid_out,
  output logic                                busy,
  output logic                                frame_done
);

  localparam int DEPTH    = (KERNEL-1)*IMG_WIDTH + KERNEL;
  localparam int OUT_SIDE = IMG_WIDTH - KERNEL + 1;
  localparam int NUM_WIN  = OUT_SIDE*OUT_SIDE;
  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int OCW      = $clog2(NUM_WIN);
  localparam int WW       = KERNEL*KERNEL*DATA_BITS;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        x_q, x_d, y_q, y_d;
  logic [OCW-1:0]       out_cnt_q, out_cnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [WW-1:0]        win_q, win_d, win_taps;
  logic                 gate_en, emit, last_pix;

  // Entry 0 of the post-shift view is the incoming pixel, so only DEPTH-1 entries need storing.
  logic [DATA_BITS-1:0] lb_q [DEPTH-1];
  logic [DATA_BITS-1:0] tap  [DEPTH];

  assign gate_en  = valid_in | busy_q | (state_q != IDLE);
  assign emit     = valid_in && (x_q >= CW'(KERNEL-1)) && (y_q >= CW'(KERNEL-1));
  assign last_pix = (x_q == CW'(IMG_WIDTH-1)) && (y_q == CW'(IMG_WIDTH-1));

  always_comb begin
    tap[0] = data_in;
    for (int i = 1; i < DEPTH; i++) tap[i] = lb_q[i-1];
  end

  // Slot (r,c) is the pixel (KERNEL-1-r) rows and (KERNEL-1-c) columns older than the newest one.
  always_comb begin
    win_taps = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_taps[(r*KERNEL+c)*DATA_BITS +: DATA_BITS] = tap[(KERNEL-1-r)*IMG_WIDTH + (KERNEL-1-c)];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    out_cnt_d = out_cnt_q;
    busy_d    = busy_q;
    win_d     = win_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (valid_in) begin
      busy_d = 1'b1;
      if (x_q == CW'(IMG_WIDTH-1)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (y_d == CW'(KERNEL-1)) state_d = STREAM;
        STREAM:  state_d = STREAM;
        default: state_d = IDLE;
      endcase
      if (emit) begin
        win_d   = win_taps;
        valid_d = 1'b1;
        if (out_cnt_q == OCW'(NUM_WIN-1)) begin
          out_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      if (last_pix) begin
        x_d     = '0;
        y_d     = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // Pulse flags update every cycle so they always drop after one beat; frame state follows the gate enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (gate_en) begin
        state_q   <= state_d;
        x_q       <= x_d;
        y_q       <= y_d;
        out_cnt_q <= out_cnt_d;
        busy_q    <= busy_d;
        win_q     <= win_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb_q[0] <= data_in;
      for (int i = 1; i < DEPTH-1; i++) lb_q[i] <= lb_q[i-1];
    end
  end

  assign window_out = win_q;
  assign valid_out  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv1_window_buf.sv
// Self-checking bench for conv1_window_buf: table of hand-computed window slots plus
// directed multi-cycle sequences (gaps, back-to-back frames, mid-frame reset).
module tb_conv1_window_buf;

  localparam int W  = 28;
  localparam int K  = 5;
  localparam int DB = 8;
  localparam int WW = K*K*DB;
  localparam int NPIX = W*W;
  localparam int NWIN = (W-K+1)*(W-K+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DB-1:0] data_in = '0;
  logic [WW-1:0] window_out;
  logic          valid_out, busy, frame_done;

  conv1_window_buf #(.IMG_WIDTH(W), .KERNEL(K), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .window_out(window_out), .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pixIdx;
    int          slot;
    logic [7:0]  expVal;
  } vec_t;

  int passCount = 0;
  int checkCount = 0;

  logic [DB-1:0] framePix [NPIX];
  logic [WW-1:0] cap  [NWIN];
  logic [WW-1:0] gold [NWIN];
  logic [WW-1:0] prevWin;
  int mx, my, winIdx, dutPulses, dutDones;
  bit mBusy;

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    mx = 0; my = 0; mBusy = 0; winIdx = 0; prevWin = '0;
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [DB-1:0] d);
    bit emit, last;
    logic [WW-1:0] expWin;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    emit = 0; last = 0; expWin = '0;
    if (v) begin
      framePix[my*W+mx] = d;
      emit = (mx >= K-1) && (my >= K-1);
      last = (mx == W-1) && (my == W-1);
      if (emit) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            expWin[(r*K+c)*DB +: DB] = framePix[(my-(K-1)+r)*W + (mx-(K-1)+c)];
      end
      if (mx == W-1) begin mx = 0; my = my + 1; end else mx = mx + 1;
      if (last) begin mx = 0; my = 0; end
      mBusy = !last;
    end
    if (valid_out) dutPulses++;
    if (frame_done) dutDones++;
    checkOutput("valid_out", WW'(valid_out), WW'(emit));
    checkOutput("frame_done", WW'(frame_done), WW'(last));
    checkOutput("busy", WW'(busy), WW'(mBusy));
    if (emit) begin
      checkOutput("window", window_out, expWin);
      if (winIdx < NWIN) cap[winIdx] = window_out;
      winIdx = last ? 0 : winIdx + 1;
    end else begin
      checkOutput("window_hold", window_out, prevWin);
    end
    prevWin = window_out;
  endtask

  task automatic doReset();
    valid_in = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", {window_out, valid_out, busy, frame_done}, '0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Feeds pixels 0..count-1 of a frame with value (idx+offset) mod 256.
  task automatic feedFrame(input int offset, input bit gaps, input int count, input bit checkFirst);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        int holes;
        holes = $urandom_range(1, 7);
        for (int g = 0; g < holes; g++) applyStimulus(1'b0, DB'($urandom));
      end
      applyStimulus(1'b1, DB'((i + offset) % 256));
      if (checkFirst && i == 116) begin
        checkOutput("f2_first_slot0", WW'(window_out[7:0]), WW'(100));
        checkOutput("f2_first_slot24", WW'(window_out[24*DB +: DB]), WW'(216));
      end
    end
  endtask

  task automatic compareGold(input string name);
    int diffs;
    diffs = 0;
    for (int w = 0; w < NWIN; w++) if (cap[w] !== gold[w]) diffs++;
    checkOutput(name, WW'(diffs), WW'(0));
  endtask

  initial begin
    vec_t vecs[9];
    vecs[0] = '{116,  0, 8'd0};
    vecs[1] = '{116,  4, 8'd4};
    vecs[2] = '{116, 20, 8'd112};
    vecs[3] = '{116, 24, 8'd116};
    vecs[4] = '{144,  0, 8'd28};
    vecs[5] = '{144, 24, 8'd144};
    vecs[6] = '{139,  0, 8'd23};
    vecs[7] = '{783, 24, 8'd15};
    vecs[8] = '{783,  0, 8'd155};

    modelReset();
    dutPulses = 0; dutDones = 0;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hA5);

    // Contiguous reference frame
    dutPulses = 0; dutDones = 0;
    for (int w = 0; w < NWIN; w++) cap[w] = '0;
    feedFrame(0, 1'b0, NPIX, 1'b0);
    checkOutput("pulses_contig", WW'(dutPulses), WW'(NWIN));
    checkOutput("dones_contig", WW'(dutDones), WW'(1));
    for (int w = 0; w < NWIN; w++) gold[w] = cap[w];
    for (int v = 0; v < 9; v++) begin
      int y, x, w;
      logic [WW-1:0] win;
      y = vecs[v].pixIdx / W;
      x = vecs[v].pixIdx % W;
      w = (y-(K-1))*(W-K+1) + (x-(K-1));
      win = gold[w];
      checkOutput($sformatf("slot_p%0d_s%0d", vecs[v].pixIdx, vecs[v].slot),
                  WW'(win[vecs[v].slot*DB +: DB]), WW'(vecs[v].expVal));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00);

    // Same frame with random valid_in holes
    dutPulses = 0; dutDones = 0;
    for (int w = 0; w < NWIN; w++) cap[w] = '0;
    feedFrame(0, 1'b1, NPIX, 1'b0);
    checkOutput("pulses_gaps", WW'(dutPulses), WW'(NWIN));
    compareGold("gaps_vs_contig");

    // Two back-to-back frames, second offset by 100
    dutPulses = 0; dutDones = 0;
    feedFrame(0, 1'b0, NPIX, 1'b0);
    feedFrame(100, 1'b0, NPIX, 1'b1);
    checkOutput("pulses_b2b", WW'(dutPulses), WW'(2*NWIN));
    checkOutput("dones_b2b", WW'(dutDones), WW'(2));

    // Reset part-way through a frame, then a fresh frame
    feedFrame(0, 1'b0, 300, 1'b0);
    doReset();
    checkOutput("busy_after_reset", WW'(busy), WW'(0));
    dutPulses = 0; dutDones = 0;
    for (int w = 0; w < NWIN; w++) cap[w] = '0;
    feedFrame(0, 1'b0, NPIX, 1'b0);
    checkOutput("pulses_after_reset", WW'(dutPulses), WW'(NWIN));
    compareGold("reset_vs_contig");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
